oreg_publish_sched: RTL
=======================

Name: oreg_publish_sched

Overview:
- Arbitrates between two frame producers and publishes their results into the shared PS-visible output register bank.
  - Position pipeline drives oreg1..4.
  - OPD pipeline drives oreg5..8.
- Each accepted frame is written one 32-bit word per cycle over a single internal write port.
- The producer's frame counter is bumped only after all four words are written, so software polling the counter always reads a coherent frame.
- Sits between the pos/opd processing chains and the top-level oreg outputs.

Parameters:
- COUNT_W, 32, width of oreg_count_pos / oreg_count_opd.
- WORD_W, 32, width of one output register word.

Ports:
- clk  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- hold_i  in  1  pause: no new frames accepted while high
- pos_valid_i  in  1  position frame available
- pos_ready_o  out  1  position frame accepted this cycle when high with valid
- pos_data_i  in  4*WORD_W  position frame, word k = bits [32k+31:32k]
- opd_valid_i  in  1  OPD frame available
- opd_ready_o  out  1  OPD frame accepted this cycle when high with valid
- opd_data_i  in  4*WORD_W  OPD frame, same word packing
- busy_o  out  1  high in any state other than IDLE
- oreg1..oreg8  out  WORD_W each  published register bank
- oreg_count_pos  out  COUNT_W  number of committed position frames
- oreg_count_opd  out  COUNT_W  number of committed OPD frames

Behaviour:
- Reset (rst_ni low, async):
  - All oreg*, counters, busy_o and the data buffer are set to 0.
  - FSM goes to IDLE.
  - last_grant is set to OPD, so position wins the first tie.
  - Both ready outputs are 0 while reset is asserted.
- FSM states: IDLE -> WRITE (beats 0..3) -> COMMIT -> IDLE.
- IDLE:
  - If hold_i=1: both readies are 0.
  - Else if exactly one valid is high: that requester's ready=1.
  - Else if both valid are high: ready goes to the requester that is not last_grant (round-robin).
  - Ready is combinational from state, hold_i, both valids and last_grant.
  - At most one ready is high per cycle.
- Accept (valid&ready at cycle T):
  - Capture the 128-bit frame and grant id into the buffer.
  - Update last_grant.
  - Go to WRITE with beat=0.
- WRITE, cycles T+1..T+4:
  - Beat k writes buffer word k to oreg(base+k); base is oreg1 for pos, oreg5 for opd.
  - A register takes its new value at the clock edge ending its beat.
  - The other bank is never touched.
- COMMIT, cycle T+5:
  - The granted counter increments by 1, modulo 2^COUNT_W (all-ones wraps to 0).
  - Go to IDLE.
- Earliest next accept is T+6, giving a sustained throughput of 1 frame per 6 cycles.
- Latency from accept to visible count increment: 5 clock edges.
- Producers must hold valid and data stable until ready. The block never drops a frame; non-granted producers stall.
- hold_i rising mid-frame does not abort: WRITE/COMMIT complete, and then no accept occurs until hold_i=0.
- Reset asserted mid-frame:
  - The frame is discarded.
  - All outputs clear immediately.
  - A partially written bank is not preserved.
- busy_o=1 in WRITE and COMMIT, and 0 in IDLE.

Test Plan:
- Reset, then pos_valid with words 0x11,0x22,0x33,0x44 at T -> pos_ready=1 at T; oreg1..4=0x11..0x44 after edges T+1..T+4; oreg_count_pos=1 after T+5; oreg5..8 and count_opd stay 0.
- Both valid continuously for 4 frames -> grant order pos, opd, pos, opd; accepts spaced 6 cycles apart; final counts 2/2; never both readies high.
- hold_i=1 with opd_valid high for 20 cycles -> opd_ready stays 0 and counts unchanged; release hold -> accept on the next cycle.
- hold_i raised at beat 2 of a pos frame -> frame finishes, count_pos increments, no further accept while held.
- Preload count_opd path to 0xFFFFFFFF (force or 2^32 frames via backdoor) and commit one opd frame -> oreg_count_opd=0.
- rst_ni pulsed low at beat 1 -> all oreg and counts read 0 asynchronously, busy_o=0; after release, the next frame publishes correctly and pos wins a tie.

Source files
------------

// File: rtl/oreg_publish_sched.sv
// Two-producer round-robin publisher: each accepted 4-word frame is written one word
// per cycle into its half of the oreg bank, then the producer's frame counter is bumped.
module oreg_publish_sched #(
  parameter int COUNT_W = 32,
  parameter int WORD_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  hold_i,
  input  logic                  pos_valid_i,
  output logic                  pos_ready_o,
  input  logic [4*WORD_W-1:0]   pos_data_i,
  input  logic                  opd_valid_i,
  output logic                  opd_ready_o,
  input  logic [4*WORD_W-1:0]   opd_data_i,
  output logic                  busy_o,
  output logic [WORD_W-1:0]     oreg1,
  output logic [WORD_W-1:0]     oreg2,
  output logic [WORD_W-1:0]     oreg3,
  output logic [WORD_W-1:0]     oreg4,
  output logic [WORD_W-1:0]     oreg5,
  output logic [WORD_W-1:0]     oreg6,
  output logic [WORD_W-1:0]     oreg7,
  output logic [WORD_W-1:0]     oreg8,
  output logic [COUNT_W-1:0]    oreg_count_pos,
  output logic [COUNT_W-1:0]    oreg_count_opd,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a frame transfers on a rising edge where valid && ready; producers keep
  // valid and data stable until then, and at most one ready is high in any cycle.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_beat;
  logic                  r_gnt;   // 1 = OPD frame in the buffer
  logic                  r_last;  // 1 = OPD was granted most recently
  logic [4*WORD_W-1:0]   r_buf;
  logic [WORD_W-1:0]     r_oreg [8];
  logic [COUNT_W-1:0]    r_cnt_pos;
  logic [COUNT_W-1:0]    r_cnt_opd;
  logic                  w_pos_rdy;
  logic                  w_opd_rdy;
  logic [WORD_W-1:0]     w_words [4];

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  for (genvar k = 0; k < 4; k++) begin : g_words
    assign w_words[k] = r_buf[k*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Readies are gated by rst_ni so nothing is offered while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_rdy   = 1'b0;
    w_opd_rdy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_ni && !hold_i) begin
          if (pos_valid_i && opd_valid_i) begin
            w_pos_rdy = r_last;
            w_opd_rdy = !r_last;
          end else begin
            w_pos_rdy = pos_valid_i;
            w_opd_rdy = opd_valid_i;
          end
          if (w_pos_rdy || w_opd_rdy) w_state_nxt = S_WRITE;
        end
      end
      S_WRITE:  if (r_beat == 2'd3) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat    <= 2'd0;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_buf     <= '0;
      r_cnt_pos <= '0;
      r_cnt_opd <= '0;
      for (int i = 0; i < 8; i++) r_oreg[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pos_rdy || w_opd_rdy) begin
            r_buf  <= w_pos_rdy ? pos_data_i : opd_data_i;
            r_gnt  <= w_opd_rdy;
            r_last <= w_opd_rdy;
            r_beat <= 2'd0;
          end
        end
        S_WRITE: begin
          r_oreg[{r_gnt, r_beat}] <= w_words[r_beat];
          r_beat                  <= r_beat + 2'd1;
        end
        S_COMMIT: begin
          if (r_gnt) r_cnt_opd <= r_cnt_opd + CNT_ONE;
          else       r_cnt_pos <= r_cnt_pos + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign pos_ready_o    = w_pos_rdy;
  assign opd_ready_o    = w_opd_rdy;
  assign busy_o         = (r_state != S_IDLE);
  assign dbg_state_o    = r_state;
  assign oreg1          = r_oreg[0];
  assign oreg2          = r_oreg[1];
  assign oreg3          = r_oreg[2];
  assign oreg4          = r_oreg[3];
  assign oreg5          = r_oreg[4];
  assign oreg6          = r_oreg[5];
  assign oreg7          = r_oreg[6];
  assign oreg8          = r_oreg[7];
  assign oreg_count_pos = r_cnt_pos;
  assign oreg_count_opd = r_cnt_opd;

endmodule
